// File: rtl/data_ram_ctrl.sv
// Data-memory controller: 256x8 RAM behind a four-state access FSM with
// programmable wait states, a one-cycle ready pulse and a held read register.
module data_ram_ctrl #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  input  logic       rd,
  input  logic       wr,
  output logic [7:0] rdata,
  output logic       ready,
  output logic       busy,
  output logic       err
);

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, DONE} state_t;

  state_t     state;
  logic [3:0] cnt;
  logic [7:0] addr_q;
  logic [7:0] wdata_q;
  logic       op_wr;
  logic [7:0] mem [256];
  logic       ram_we;

  // RAM has no reset; a write only fires from ACCESS, so reset drops it.
  assign ram_we = (state == ACCESS) && op_wr;

  always_ff @(posedge clk) begin
    if (ram_we) mem[addr_q] <= wdata_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      op_wr   <= 1'b0;
      rdata   <= '0;
      ready   <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
    end else begin
      ready <= 1'b0;
      err   <= 1'b0;
      case (state)
        IDLE: begin
          if (rd && wr) begin
            err <= 1'b1;
          end else if (rd || wr) begin
            addr_q  <= addr;
            wdata_q <= wdata;
            op_wr   <= wr;
            cnt     <= 4'(WAIT_CYCLES);
            busy    <= 1'b1;
            state   <= WAIT;
          end
        end
        // WAIT always spends WAIT_CYCLES+1 cycles so latency is WAIT_CYCLES+2.
        WAIT: begin
          if (cnt == '0) state <= ACCESS;
          else           cnt   <= cnt - 4'd1;
        end
        ACCESS: begin
          if (!op_wr) rdata <= mem[addr_q];
          ready <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
